// File: rtl/red_pitaya_pwm_multi.sv
// -----------------------------------------------------------------------------
// red_pitaya_pwm_multi
//
// Multi-channel PWM generator for the RC-filtered slow analog outputs.
// Each channel converts a fixed-point duty word {coarse[VW-1:0], frac[DW-1:0]}
// into a left-aligned PWM stream. The fractional part is resolved over
// successive periods by a first-order error-feedback accumulator, so the
// mean high time over 2^DW periods equals coarse + frac/2^DW exactly.
//
// Configuration is double-buffered. A cfg_we strobe captures cfg_i/dith_i
// into a shadow copy. The shadow copy moves to the active copy only on a
// frame boundary, which is the last period of a 2^FRL2-period frame.
// pwm_s is high during the cycle that ends a frame.
//
// Ports
//   clk       in   1            system clock
//   rst       in   1            synchronous reset, active-high
//   cfg_i     in   NCH*(VW+DW)  channel k at [k*(VW+DW) +: VW+DW] = {coarse, frac}
//   dith_i    in   NCH          per-channel dither enable, captured with cfg_i
//   cfg_we    in   1            one-cycle strobe loading cfg_i/dith_i into shadow
//   cfg_pend  out  1            shadow holds data not yet transferred to active
//   pwm_o     out  NCH          PWM outputs (registered)
//   pwm_s     out  1            frame sync pulse (registered)
// -----------------------------------------------------------------------------
module red_pitaya_pwm_multi #(
    parameter int NCH  = 4,
    parameter int VW   = 8,
    parameter int DW   = 16,
    parameter int FULL = 255,
    parameter int FRL2 = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH*(VW+DW)-1:0]   cfg_i,
    input  logic [NCH-1:0]           dith_i,
    input  logic                     cfg_we,
    output logic                     cfg_pend,
    output logic [NCH-1:0]           pwm_o,
    output logic                     pwm_s
);

    localparam int CW = VW + DW;

    // Counter terminal values. FULL is the last counter value, so a period
    // lasts FULL+1 cycles and the counter wraps there, not at 2^VW.
    localparam logic [VW-1:0]   VCNT_LAST = VW'(FULL);
    localparam logic [VW-1:0]   VCNT_PRE  = VW'(FULL - 1);
    localparam logic [FRL2-1:0] FCNT_LAST = {FRL2{1'b1}};

    // Field extraction helpers for the packed configuration vector.
    function automatic logic [VW-1:0] cfg_coarse(input logic [NCH*CW-1:0] cfg, input int k);
        return cfg[k*CW+DW +: VW];
    endfunction

    function automatic logic [DW-1:0] cfg_frac(input logic [NCH*CW-1:0] cfg, input int k);
        return cfg[k*CW +: DW];
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [VW-1:0]     vcnt_r;
    logic [FRL2-1:0]   fcnt_r;
    logic [NCH*CW-1:0] shd_cfg_r;
    logic [NCH-1:0]    shd_dith_r;
    logic [NCH*CW-1:0] act_cfg_r;
    logic [NCH-1:0]    act_dith_r;
    logic [DW-1:0]     acc_r  [NCH];
    logic [VW:0]       duty_r [NCH];

    // -------------------------------------------------------------------------
    // Combinational decode
    // -------------------------------------------------------------------------
    logic              pb_s;
    logic              fb_s;
    logic              xfer_s;
    logic [NCH*CW-1:0] nxt_cfg_s;
    logic [NCH-1:0]    nxt_dith_s;
    logic [DW:0]       sum_s       [NCH];
    logic [VW:0]       dith_duty_s [NCH];
    logic [VW:0]       flat_duty_s [NCH];

    assign pb_s   = (vcnt_r == VCNT_LAST);
    assign fb_s   = pb_s && (fcnt_r == FCNT_LAST);
    assign xfer_s = fb_s && cfg_pend;

    // Active configuration as it will be after this edge; the duty update on a
    // frame boundary must already see freshly transferred values.
    always_comb begin
        nxt_cfg_s  = act_cfg_r;
        nxt_dith_s = act_dith_r;
        if (xfer_s) begin
            nxt_cfg_s  = shd_cfg_r;
            nxt_dith_s = shd_dith_r;
        end else begin
            nxt_cfg_s  = act_cfg_r;
            nxt_dith_s = act_dith_r;
        end
    end

    // Error-feedback sum per channel; the carry out of the DW+1-bit sum is the
    // extra high cycle for the coming period. Duty is VW+1 bits so that
    // coarse = 2^VW-1 plus a carry never wraps to zero.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            sum_s[k]       = {1'b0, acc_r[k]} + {1'b0, cfg_frac(nxt_cfg_s, k)};
            flat_duty_s[k] = {1'b0, cfg_coarse(nxt_cfg_s, k)};
            dith_duty_s[k] = flat_duty_s[k] + {{VW{1'b0}}, sum_s[k][DW]};
        end
    end

    // -------------------------------------------------------------------------
    // Sequential logic
    // -------------------------------------------------------------------------

    // Period counter (0..FULL) and frame counter (advances once per period).
    always_ff @(posedge clk) begin
        if (rst) begin
            vcnt_r <= {VW{1'b0}};
            fcnt_r <= {FRL2{1'b0}};
        end else if (pb_s) begin
            vcnt_r <= {VW{1'b0}};
            fcnt_r <= fcnt_r + FRL2'(1);
        end else begin
            vcnt_r <= vcnt_r + VW'(1);
        end
    end

    // Shadow registers and pending flag; a write on the frame-boundary edge
    // wins over the clear, so it is held for the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            shd_cfg_r  <= {(NCH*CW){1'b0}};
            shd_dith_r <= {NCH{1'b0}};
            cfg_pend   <= 1'b0;
        end else if (cfg_we) begin
            shd_cfg_r  <= cfg_i;
            shd_dith_r <= dith_i;
            cfg_pend   <= 1'b1;
        end else if (fb_s) begin
            cfg_pend   <= 1'b0;
        end
    end

    // Active configuration, replaced from the shadow only on a frame boundary.
    // The shadow value used here is the one held before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_cfg_r  <= {(NCH*CW){1'b0}};
            act_dith_r <= {NCH{1'b0}};
        end else begin
            act_cfg_r  <= nxt_cfg_s;
            act_dith_r <= nxt_dith_s;
        end
    end

    // Per-channel duty and dither accumulator, refreshed once per period.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) begin
                acc_r[k]  <= {DW{1'b0}};
                duty_r[k] <= {(VW+1){1'b0}};
            end
        end else if (pb_s) begin
            for (int k = 0; k < NCH; k++) begin
                if (nxt_dith_s[k]) begin
                    acc_r[k]  <= sum_s[k][DW-1:0];
                    duty_r[k] <= dith_duty_s[k];
                end else begin
                    acc_r[k]  <= {DW{1'b0}};
                    duty_r[k] <= flat_duty_s[k];
                end
            end
        end
    end

    // PWM comparators. The counter is zero-extended so a duty of FULL+1 or
    // more keeps the pin high through the wrap without a one-cycle dip.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_o <= {NCH{1'b0}};
        end else begin
            for (int k = 0; k < NCH; k++) begin
                pwm_o[k] <= ({1'b0, vcnt_r} < duty_r[k]);
            end
        end
    end

    // Frame sync: decoded one cycle early so the registered pulse coincides
    // with the frame-boundary cycle itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_s <= 1'b0;
        end else begin
            pwm_s <= (fcnt_r == FCNT_LAST) && (vcnt_r == VCNT_PRE);
        end
    end

endmodule

// File: tb/tb_red_pitaya_pwm_multi.sv
module tb_red_pitaya_pwm_multi;

    localparam int NCH = 4;
    localparam int VW  = 8;
    localparam int DW  = 16;
    localparam int CW  = VW + DW;

    logic                 clk;
    logic                 rst;
    logic [NCH*CW-1:0]    cfg_i;
    logic [NCH-1:0]       dith_i;
    logic                 cfg_we;
    logic                 cfg_pend;
    logic [NCH-1:0]       pwm_o;
    logic                 pwm_s;
    logic                 cfg_pend6;
    logic [NCH-1:0]       pwm_o6;
    logic                 pwm_s6;

    int n_chk;
    int n_pass;
    int   hi      [0:3][0:7];
    logic first_v [0:3][0:7];
    logic last_v  [0:3][0:7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    red_pitaya_pwm_multi #(.NCH(4), .VW(8), .DW(16), .FULL(255), .FRL2(4)) u_dut (
        .clk(clk), .rst(rst), .cfg_i(cfg_i), .dith_i(dith_i), .cfg_we(cfg_we),
        .cfg_pend(cfg_pend), .pwm_o(pwm_o), .pwm_s(pwm_s)
    );

    red_pitaya_pwm_multi #(.NCH(4), .VW(8), .DW(16), .FULL(99), .FRL2(2)) u_dut6 (
        .clk(clk), .rst(rst), .cfg_i(cfg_i), .dith_i(dith_i), .cfg_we(cfg_we),
        .cfg_pend(cfg_pend6), .pwm_o(pwm_o6), .pwm_s(pwm_s6)
    );

    // Three reset edges with a clean config; returns at the negedge in the
    // first cycle after reset (counter value 0).
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cfg_we = 1'b0; cfg_i = '0; dith_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_ch(input int ch, input logic [7:0] coarse, input logic [15:0] frac, input logic d);
        cfg_i[ch*CW +: CW] = {coarse, frac};
        dith_i[ch] = d;
    endtask

    // Pulse cfg_we for the current cycle; returns one negedge later.
    task automatic pulse_we();
        cfg_we = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Wait (bounded) for the negedge inside a pwm_s cycle.
    task automatic wait_fs(input bit sel, input int budget, output bit ok, output int n, output bit any_hi);
        ok = 1'b0; n = 0; any_hi = 1'b0;
        while (n < budget && !ok) begin
            @(negedge clk);
            n++;
            if ((sel ? pwm_s6 : pwm_s) === 1'b1) ok = 1'b1;
            else any_hi = any_hi | (|(sel ? pwm_o6 : pwm_o));
        end
    endtask

    // Sample nper consecutive output periods of full+1 cycles each.
    task automatic measure(input bit sel, input int nper, input int full);
        logic [3:0] v;
        for (int c = 0; c < 4; c++)
            for (int p = 0; p < 8; p++) begin
                hi[c][p] = 0; first_v[c][p] = 1'b0; last_v[c][p] = 1'b0;
            end
        for (int p = 0; p < nper; p++)
            for (int s = 0; s <= full; s++) begin
                @(negedge clk);
                v = sel ? pwm_o6 : pwm_o;
                for (int c = 0; c < 4; c++) begin
                    if (v[c] === 1'b1) hi[c][p] = hi[c][p] + 1;
                    if (s == 0)    first_v[c][p] = v[c];
                    if (s == full) last_v[c][p]  = v[c];
                end
            end
    endtask

    task automatic test_reset();
        bit ok; int n; bit any;
        do_reset();
        set_ch(0, 8'd200, 16'h1234, 1'b1);
        pulse_we();
        repeat (50) @(negedge clk);
        // Reset mid-operation with cfg_we held high throughout.
        rst = 1'b1; cfg_we = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if (pwm_o !== 4'b0000) $display("FAIL rst_pwm_o: got %b want 0000", pwm_o); else n_pass++;
        n_chk++; if (pwm_s !== 1'b0) $display("FAIL rst_pwm_s: got %b want 0", pwm_s); else n_pass++;
        n_chk++; if (cfg_pend !== 1'b0) $display("FAIL rst_cfg_pend: got %b want 0", cfg_pend); else n_pass++;
        rst = 1'b0; cfg_we = 1'b0;
        wait_fs(1'b0, 5000, ok, n, any);
        n_chk++; if (!ok || n != 4095) $display("FAIL rst_first_fs: got ok=%0d n=%0d want n=4095", ok, n); else n_pass++;
        n_chk++; if (any !== 1'b0) $display("FAIL rst_quiet: got any_hi=%0d want 0", any); else n_pass++;
        n_chk++; if (cfg_pend !== 1'b0) $display("FAIL rst_no_pend: got %b want 0", cfg_pend); else n_pass++;
        @(negedge clk);
        measure(1'b0, 1, 255);
        n_chk++; if (hi[0][0] != 0) $display("FAIL rst_no_apply: got %0d high want 0", hi[0][0]); else n_pass++;
    endtask

    task automatic test_coarse();
        bit ok; int n; bit any;
        do_reset();
        set_ch(0, 8'd128, 16'h0000, 1'b0);
        pulse_we();
        wait_fs(1'b0, 5000, ok, n, any);
        n_chk++; if (!ok) $display("FAIL coarse_fs_timeout: got none want pwm_s"); else n_pass++;
        @(negedge clk);
        measure(1'b0, 2, 255);
        for (int p = 0; p < 2; p++) begin
            n_chk++; if (hi[0][p] != 128) $display("FAIL coarse_hi p%0d: got %0d want 128", p, hi[0][p]); else n_pass++;
        end
        n_chk++; if (first_v[0][0] !== 1'b1 || last_v[0][0] !== 1'b0)
            $display("FAIL coarse_align: got first=%b last=%b want 1/0", first_v[0][0], last_v[0][0]); else n_pass++;
        for (int c = 1; c < 4; c++) begin
            n_chk++; if (hi[c][0] != 0) $display("FAIL coarse_idle ch%0d: got %0d want 0", c, hi[c][0]); else n_pass++;
        end
    endtask

    task automatic test_dither();
        bit ok; int n; bit any; int sum;
        int exp_hi [0:3];
        exp_hi = '{10, 10, 10, 11};
        do_reset();
        set_ch(1, 8'd10, 16'h4000, 1'b1);
        pulse_we();
        wait_fs(1'b0, 5000, ok, n, any);
        n_chk++; if (!ok) $display("FAIL dith_fs_timeout: got none want pwm_s"); else n_pass++;
        @(negedge clk);
        measure(1'b0, 8, 255);
        sum = 0;
        for (int p = 0; p < 8; p++) begin
            n_chk++; if (hi[1][p] != exp_hi[p % 4]) $display("FAIL dith_hi p%0d: got %0d want %0d", p, hi[1][p], exp_hi[p % 4]); else n_pass++;
            if (p < 4) sum += hi[1][p];
        end
        n_chk++; if (sum != 41) $display("FAIL dith_sum4: got %0d want 41", sum); else n_pass++;
    endtask

    task automatic test_dither_max();
        bit ok; int n; bit any;
        int exp_hi [0:3];
        exp_hi = '{255, 256, 256, 256};
        do_reset();
        set_ch(2, 8'd255, 16'hFFFF, 1'b1);
        pulse_we();
        wait_fs(1'b0, 5000, ok, n, any);
        n_chk++; if (!ok) $display("FAIL dmax_fs_timeout: got none want pwm_s"); else n_pass++;
        @(negedge clk);
        measure(1'b0, 4, 255);
        for (int p = 0; p < 4; p++) begin
            n_chk++; if (hi[2][p] != exp_hi[p]) $display("FAIL dmax_hi p%0d: got %0d want %0d", p, hi[2][p], exp_hi[p]); else n_pass++;
        end
        n_chk++; if (last_v[2][1] !== 1'b1 || first_v[2][2] !== 1'b1)
            $display("FAIL dmax_wrap: got last=%b first=%b want 1/1", last_v[2][1], first_v[2][2]); else n_pass++;
    endtask

    task automatic test_pending();
        bit ok; int n; bit any;
        do_reset();
        repeat (100) @(negedge clk);
        set_ch(0, 8'd200, 16'h0000, 1'b0);
        pulse_we();
        n_chk++; if (cfg_pend !== 1'b1) $display("FAIL pend_set: got %b want 1", cfg_pend); else n_pass++;
        wait_fs(1'b0, 5000, ok, n, any);
        n_chk++; if (!ok || any !== 1'b0) $display("FAIL pend_hold: got ok=%0d any_hi=%0d want 1/0", ok, any); else n_pass++;
        n_chk++; if (cfg_pend !== 1'b1) $display("FAIL pend_before_fb: got %b want 1", cfg_pend); else n_pass++;
        // New write lands exactly on the frame-boundary edge.
        set_ch(0, 8'd50, 16'h0000, 1'b0);
        pulse_we();
        n_chk++; if (cfg_pend !== 1'b1) $display("FAIL pend_we_on_fb: got %b want 1", cfg_pend); else n_pass++;
        measure(1'b0, 1, 255);
        n_chk++; if (hi[0][0] != 200) $display("FAIL pend_first_apply: got %0d want 200", hi[0][0]); else n_pass++;
        wait_fs(1'b0, 5000, ok, n, any);
        n_chk++; if (!ok || cfg_pend !== 1'b1) $display("FAIL pend_second_fb: got ok=%0d pend=%b want 1/1", ok, cfg_pend); else n_pass++;
        @(negedge clk);
        n_chk++; if (cfg_pend !== 1'b0) $display("FAIL pend_clear: got %b want 0", cfg_pend); else n_pass++;
        measure(1'b0, 1, 255);
        n_chk++; if (hi[0][0] != 50) $display("FAIL pend_second_apply: got %0d want 50", hi[0][0]); else n_pass++;
    endtask

    task automatic test_small_frame();
        bit ok; int n; bit any;
        do_reset();
        set_ch(0, 8'd30, 16'h0000, 1'b0);
        pulse_we();
        wait_fs(1'b1, 1000, ok, n, any);
        // The pulse edge already consumed one negedge inside pulse_we.
        n_chk++; if (!ok || n != 398) $display("FAIL small_first_fs: got ok=%0d n=%0d want n=398", ok, n); else n_pass++;
        @(negedge clk);
        measure(1'b1, 1, 99);
        n_chk++; if (hi[0][0] != 30 || first_v[0][0] !== 1'b1)
            $display("FAIL small_hi: got %0d first=%b want 30/1", hi[0][0], first_v[0][0]); else n_pass++;
        wait_fs(1'b1, 1000, ok, n, any);
        n_chk++; if (!ok || n != 299) $display("FAIL small_fs_gap1: got ok=%0d n=%0d want n=299", ok, n); else n_pass++;
        @(negedge clk);
        n_chk++; if (pwm_s6 !== 1'b0) $display("FAIL small_fs_width: got %b want 0", pwm_s6); else n_pass++;
        wait_fs(1'b1, 1000, ok, n, any);
        n_chk++; if (!ok || n != 399) $display("FAIL small_fs_period: got ok=%0d n=%0d want n=399", ok, n); else n_pass++;
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rst = 1'b1; cfg_we = 1'b0; cfg_i = '0; dith_i = '0;
        test_reset();
        test_coarse();
        test_dither();
        test_dither_max();
        test_pending();
        test_small_frame();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
